// File: rtl/stream_frame_tx.sv
// Ping-pong frame buffer: collects FRAME_ROWS host rows per bank and replays each full bank
// as one contiguous 4-lane burst, bursts separated by at least MIN_GAP idle cycles.
module stream_frame_tx #(
  parameter int unsigned FRAME_ROWS = 4,
  parameter int unsigned MIN_GAP    = 1,
  parameter int unsigned C_IWL      = 5,
  parameter int unsigned C_FWL      = 15,
  localparam int unsigned W         = C_IWL + C_FWL
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic signed [W-1:0] i_data_1,
  input  logic signed [W-1:0] i_data_2,
  input  logic signed [W-1:0] i_data_3,
  input  logic signed [W-1:0] i_data_4,
  output logic                o_valid,
  output logic signed [W-1:0] o_data_1,
  output logic signed [W-1:0] o_data_2,
  output logic signed [W-1:0] o_data_3,
  output logic signed [W-1:0] o_data_4,
  output logic                o_busy,
  output logic [15:0]         o_frames_sent
);
  localparam int unsigned RowW = $clog2(FRAME_ROWS);
  localparam int unsigned GapW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(FRAME_ROWS - 1);
  localparam logic [GapW-1:0] GapInit = GapW'(MIN_GAP - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e          state_q;
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, rd_bank_q;
  logic [RowW-1:0] wr_row_q, rd_row_q;
  logic [GapW-1:0] gap_q;
  logic            valid_q, busy_q;
  logic [4*W-1:0]  data_q;
  logic [15:0]     frames_q;
  logic [4*W-1:0]  mem_q [2][FRAME_ROWS];

  logic wr_en, wr_last, tx_done, tx_start;

  assign o_ready  = ~full_q[wr_bank_q];
  assign wr_en    = i_valid & o_ready;
  assign wr_last  = wr_en & (wr_row_q == LastRow);
  // rd_row wraps to 0 once the last row is on the bus, marking the burst as complete
  assign tx_done  = (state_q == StSend) && (rd_row_q == '0);
  // A burst may start from IDLE or directly out of the final GAP cycle
  assign tx_start = full_q[rd_bank_q] &&
                    ((state_q == StIdle) || ((state_q == StGap) && (gap_q == '0)));

  // Set and clear always target different banks: one is empty, the other full
  always_comb begin
    full_d = full_q;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (tx_done) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (wr_en && !i_flush) begin
      mem_q[wr_bank_q][wr_row_q] <= {i_data_4, i_data_3, i_data_2, i_data_1};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_row_q  <= '0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      frames_q  <= '0;
    end else if (i_flush) begin
      state_q   <= StIdle;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_row_q  <= '0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      frames_q  <= '0;
    end else begin
      full_q <= full_d;
      if (wr_en) begin
        wr_row_q <= wr_last ? '0 : wr_row_q + 1'b1;
        if (wr_last) wr_bank_q <= ~wr_bank_q;
      end
      if (tx_start) begin
        state_q  <= StSend;
        valid_q  <= 1'b1;
        busy_q   <= 1'b1;
        data_q   <= mem_q[rd_bank_q][0];
        rd_row_q <= RowW'(1);
      end else begin
        unique case (state_q)
          StIdle: ;
          StSend: begin
            if (tx_done) begin
              state_q   <= StGap;
              valid_q   <= 1'b0;
              data_q    <= '0;
              rd_bank_q <= ~rd_bank_q;
              frames_q  <= frames_q + 16'd1;
              gap_q     <= GapInit;
            end else begin
              data_q   <= mem_q[rd_bank_q][rd_row_q];
              rd_row_q <= (rd_row_q == LastRow) ? '0 : rd_row_q + 1'b1;
            end
          end
          StGap: begin
            if (gap_q == '0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign o_valid       = valid_q;
  assign o_busy        = busy_q;
  assign o_frames_sent = frames_q;
  assign o_data_1      = data_q[W-1:0];
  assign o_data_2      = data_q[2*W-1:W];
  assign o_data_3      = data_q[3*W-1:2*W];
  assign o_data_4      = data_q[4*W-1:3*W];

endmodule

// File: tb/tb_stream_frame_tx.sv
// Scoreboard bench for stream_frame_tx: accepted rows are queued and checked in order
// against every o_valid cycle; per-scenario tasks check timing, gaps, flush and reset.
module tb_stream_frame_tx;
  localparam int W = 20;

  logic Clk = 1'b0, Reset = 1'b1, i_flush = 1'b0, i_valid = 1'b0;
  logic v5 = 1'b0, flush5 = 1'b0;
  logic signed [W-1:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  logic o_ready, o_valid, o_busy;
  logic signed [W-1:0] q1, q2, q3, q4;
  logic [15:0] o_frames_sent;
  logic r5, v5o, b5;
  logic signed [W-1:0] p1, p2, p3, p4;
  logic [15:0] f5;

  int n_run = 0, n_fail = 0;
  logic [4*W-1:0] sb[$];
  logic [4*W-1:0] exp_row;
  int bursts[$];
  int gaps[$];
  int cur_len = 0, low_len = 0;
  bit seen = 0, prev_v = 0, stall_seen = 0;

  always #5 Clk = ~Clk;

  stream_frame_tx #(.FRAME_ROWS(4), .MIN_GAP(1), .C_IWL(5), .C_FWL(15)) dut (
    .Clk(Clk), .Reset(Reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_1(d1), .i_data_2(d2), .i_data_3(d3), .i_data_4(d4),
    .o_valid(o_valid), .o_data_1(q1), .o_data_2(q2), .o_data_3(q3), .o_data_4(q4),
    .o_busy(o_busy), .o_frames_sent(o_frames_sent)
  );

  stream_frame_tx #(.FRAME_ROWS(4), .MIN_GAP(5), .C_IWL(5), .C_FWL(15)) dut5 (
    .Clk(Clk), .Reset(Reset), .i_flush(flush5), .i_valid(v5), .o_ready(r5),
    .i_data_1(d1), .i_data_2(d2), .i_data_3(d3), .i_data_4(d4),
    .o_valid(v5o), .o_data_1(p1), .o_data_2(p2), .o_data_3(p3), .o_data_4(p4),
    .o_busy(b5), .o_frames_sent(f5)
  );

  // Accept side: rows enter the scoreboard exactly when the handshake completes
  always @(posedge Clk) begin
    if (Reset && !i_flush && i_valid && o_ready) sb.push_back({d4, d3, d2, d1});
  end

  // Output side: every valid cycle must match the oldest pending row; track run lengths
  always @(negedge Clk) begin
    if (o_valid) begin
      if (!prev_v && seen) gaps.push_back(low_len);
      cur_len++;
      seen = 1;
      n_run++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_row: got %h, expected no output (nothing pending)", {q4, q3, q2, q1});
      end else begin
        exp_row = sb.pop_front();
        if ({q4, q3, q2, q1} !== exp_row) begin
          n_fail++;
          $display("FAIL sb_row: got %h, expected %h", {q4, q3, q2, q1}, exp_row);
        end
      end
    end else begin
      if (prev_v) begin
        bursts.push_back(cur_len);
        cur_len = 0;
        low_len = 0;
      end
      low_len++;
    end
    prev_v = o_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic mon_clear();
    sb.delete();
    bursts.delete();
    gaps.delete();
    cur_len = 0;
    low_len = 0;
    seen = 0;
    prev_v = 0;
  endtask

  task automatic do_reset();
    i_valid = 0;
    i_flush = 0;
    v5 = 0;
    Reset = 0;
    repeat (2) @(posedge Clk);
    #3 Reset = 1;
    @(posedge Clk);
    #1 mon_clear();
  endtask

  // Drives one row and holds it until the handshake completes (called at posedge+1)
  task automatic send_row(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] e);
    bit acc = 0;
    int n = 0;
    i_valid = 1;
    d1 = a; d2 = b; d3 = c; d4 = e;
    while (!acc && n < 100) begin
      @(negedge Clk);
      acc = o_ready;
      @(posedge Clk);
      #1;
      n++;
    end
    if (n > 1) stall_seen = 1;
    i_valid = 0;
    n_run++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_row_timeout: o_ready=%b, required 1 within 100 cycles", acc);
    end
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < 4; k++)
      send_row(W'(base + 4*k + 1), W'(base + 4*k + 2), W'(base + 4*k + 3), W'(base + 4*k + 4));
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge Clk);
      if (!o_valid && !o_busy && sb.size() == 0) ok = 1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #1 Reset = 0;
    #13;
    n_run++;
    if ({o_valid, o_busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: valid,busy=%b, required 00", {o_valid, o_busy});
    end
    n_run++;
    if ({q4, q3, q2, q1} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h, required 0", {q4, q3, q2, q1});
    end
    n_run++;
    if (o_frames_sent !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d, required 0", o_frames_sent);
    end
    @(posedge Clk);
    #3 Reset = 1;
    @(negedge Clk);
    n_run++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: ready,valid=%b%b, required 10", o_ready, o_valid);
    end
    @(posedge Clk);
    #1 mon_clear();
  endtask

  task automatic test_single_frame();
    bit ok;
    do_reset();
    send_frame(0);
    n_run++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: o_valid=%b at accept edge, required 0", o_valid);
    end
    @(posedge Clk);
    #1;
    n_run++;
    if (o_valid !== 1'b1 || q1 !== W'(1)) begin
      n_fail++; $display("FAIL latency_row0: valid=%b lane1=%0d, required 1 and 1", o_valid, q1);
    end
    wait_idle(ok);
    n_run++;
    if (!ok) begin n_fail++; $display("FAIL single_idle: ok=%b, required 1", ok); end
    n_run++;
    if (bursts.size() !== 1) begin
      n_fail++; $display("FAIL single_bursts: count=%0d, required 1", bursts.size());
    end else if (bursts[0] !== 4) begin
      n_fail++; $display("FAIL single_bursts: length=%0d, required 4", bursts[0]);
    end
    n_run++;
    if (o_frames_sent !== 16'd1) begin
      n_fail++; $display("FAIL single_count: got %0d, required 1", o_frames_sent);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad_b = 0, bad_g = 0;
    do_reset();
    stall_seen = 0;
    for (int k = 0; k < 12; k++)
      send_row(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    wait_idle(ok);
    n_run++;
    if (!ok) begin n_fail++; $display("FAIL b2b_idle: ok=%b, required 1", ok); end
    n_run++;
    if (stall_seen !== 1'b1) begin
      n_fail++; $display("FAIL b2b_stall: stall seen=%b, required 1", stall_seen);
    end
    foreach (bursts[i]) if (bursts[i] != 4) bad_b++;
    foreach (gaps[i]) if (gaps[i] != 1) bad_g++;
    n_run++;
    if (bursts.size() !== 3 || bad_b !== 0) begin
      n_fail++; $display("FAIL b2b_bursts: count=%0d bad=%0d, required 3 and 0", bursts.size(), bad_b);
    end
    n_run++;
    if (gaps.size() !== 2 || bad_g !== 0) begin
      n_fail++; $display("FAIL b2b_gaps: count=%0d bad=%0d, required 2 and 0", gaps.size(), bad_g);
    end
    n_run++;
    if (o_frames_sent !== 16'd3) begin
      n_fail++; $display("FAIL b2b_count: got %0d, required 3", o_frames_sent);
    end
  endtask

  task automatic test_backpressure();
    bit ok, rdy = 0, v_before = 0, v_at = 1;
    int n = 0;
    do_reset();
    send_frame(0);
    send_frame(16);
    i_valid = 1;
    d1 = W'(33); d2 = W'(34); d3 = W'(35); d4 = W'(36);
    while (!rdy && n < 50) begin
      @(negedge Clk);
      rdy = o_ready;
      if (!rdy) v_before = o_valid;
      else v_at = o_valid;
      n++;
      if (!rdy) begin
        @(posedge Clk);
        #1;
      end
    end
    @(posedge Clk);
    #1 i_valid = 0;
    n_run++;
    if (rdy !== 1'b1 || n !== 2) begin
      n_fail++; $display("FAIL bp_wait: ready=%b after %0d cycles, required 1 after 2", rdy, n);
    end
    n_run++;
    if (v_before !== 1'b1 || v_at !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: valid stalled/released=%b%b, required 10", v_before, v_at);
    end
    send_row(W'(37), W'(38), W'(39), W'(40));
    send_row(W'(41), W'(42), W'(43), W'(44));
    send_row(W'(45), W'(46), W'(47), W'(48));
    wait_idle(ok);
    n_run++;
    if (!ok || o_frames_sent !== 16'd3) begin
      n_fail++; $display("FAIL bp_done: idle=%b count=%0d, required 1 and 3", ok, o_frames_sent);
    end
  endtask

  task automatic test_min_gap5();
    bit s[40];
    logic [W-1:0] pd[40];
    int runs[$];
    int len = 1, not_rdy = 0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      v5 = (k < 8);
      if (k < 8) begin
        d1 = W'(4*k + 1); d2 = W'(4*k + 2); d3 = W'(4*k + 3); d4 = W'(4*k + 4);
      end
      @(negedge Clk);
      if (k < 8 && r5 !== 1'b1) not_rdy++;
      s[k] = v5o;
      pd[k] = p1;
      @(posedge Clk);
      #1;
    end
    v5 = 0;
    for (int i = 1; i < 40; i++) begin
      if (s[i] == s[i-1]) len++;
      else begin
        runs.push_back(len);
        len = 1;
      end
    end
    runs.push_back(len);
    n_run++;
    if (not_rdy !== 0) begin
      n_fail++; $display("FAIL gap5_ready: %0d writes stalled, required 0", not_rdy);
    end
    n_run++;
    if (runs.size() < 5) begin
      n_fail++; $display("FAIL gap5_runs: %0d runs, required at least 5", runs.size());
    end else if (runs[1] !== 4 || runs[2] !== 5 || runs[3] !== 4) begin
      n_fail++;
      $display("FAIL gap5_runs: high/low/high=%0d/%0d/%0d, required 4/5/4", runs[1], runs[2], runs[3]);
    end
    n_run++;
    if (pd[5] !== W'(1) || pd[14] !== W'(17)) begin
      n_fail++; $display("FAIL gap5_data: row0 lanes=%0d/%0d, required 1/17", pd[5], pd[14]);
    end
    n_run++;
    if (f5 !== 16'd2) begin
      n_fail++; $display("FAIL gap5_count: got %0d, required 2", f5);
    end
  endtask

  task automatic test_flush();
    bit ok;
    do_reset();
    send_frame(0);
    repeat (3) @(negedge Clk);
    i_flush = 1;
    i_valid = 1;
    d1 = W'(99); d2 = W'(98); d3 = W'(97); d4 = W'(96);
    @(posedge Clk);
    #1;
    i_flush = 0;
    i_valid = 0;
    @(negedge Clk);
    n_run++;
    if ({o_valid, o_ready, o_busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL flush_state: valid,ready,busy=%b, required 010", {o_valid, o_ready, o_busy});
    end
    n_run++;
    if (o_frames_sent !== 16'd0 || q1 !== '0) begin
      n_fail++; $display("FAIL flush_clear: count=%0d lane1=%0d, required 0 and 0", o_frames_sent, q1);
    end
    @(posedge Clk);
    #1 mon_clear();
    send_frame(100);
    wait_idle(ok);
    n_run++;
    if (!ok || bursts.size() !== 1 || o_frames_sent !== 16'd1) begin
      n_fail++;
      $display("FAIL flush_resume: idle=%b bursts=%0d count=%0d, required 1/1/1", ok,
               bursts.size(), o_frames_sent);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int n = 0;
    do_reset();
    send_frame(0);
    wait_idle(ok);
    send_frame(20);
    while (!o_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    i_valid = 1;
    d1 = W'(7); d2 = W'(7); d3 = W'(7); d4 = W'(7);
    #2 Reset = 0;
    #1;
    n_run++;
    if ({o_valid, o_busy} !== 2'b00 || {q4, q3, q2, q1} !== '0) begin
      n_fail++; $display("FAIL async_out: valid,busy=%b data=%h, required 00 and 0",
                         {o_valid, o_busy}, {q4, q3, q2, q1});
    end
    n_run++;
    if (o_frames_sent !== 16'd0) begin
      n_fail++; $display("FAIL async_count: got %0d, required 0", o_frames_sent);
    end
    repeat (2) @(posedge Clk);
    i_valid = 0;
    #3 Reset = 1;
    @(posedge Clk);
    #1 mon_clear();
    n_run++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_ready: got %b, required 1", o_ready);
    end
    send_frame(60);
    wait_idle(ok);
    n_run++;
    if (!ok || o_frames_sent !== 16'd1) begin
      n_fail++; $display("FAIL async_resume: idle=%b count=%0d, required 1 and 1", ok, o_frames_sent);
    end
    force dut.frames_q = 16'hFFFF;
    #1 release dut.frames_q;
    send_frame(80);
    wait_idle(ok);
    n_run++;
    if (!ok || o_frames_sent !== 16'd0) begin
      n_fail++; $display("FAIL count_wrap: idle=%b count=%0d, required 1 and 0", ok, o_frames_sent);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_min_gap5();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
